// File: rtl/onehot_pulse_decoder.sv
// ---------------------------------------------------------------------------
// onehot_pulse_decoder
//   Converts an accepted binary index into a registered one-hot strobe that is
//   held for PULSE_LEN cycles and then followed by GAP_LEN low cycles. A
//   valid/ready handshake throttles the source.
//
//   Optional feature (macro DEC_PENDING_EN): a one-entry pending slot. While a
//   pulse or gap is in progress, one request can be parked; it launches on the
//   cycle the FSM would otherwise return to IDLE, so back-to-back pulses need
//   no IDLE cycle in between. With the macro undefined, requests are only
//   taken in IDLE.
//
// Handshake: a request transfers on a rising clk edge where in_valid and
//   in_ready are both high. in_ready is decoded from registered state only and
//   never looks at in_valid; in_idx is sampled only when the transfer happens.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous reset, active-high
//   in_valid     in   1      request valid
//   in_ready     out  1      request can be taken this cycle
//   in_idx       in   IDX_W  binary line index, sampled on accept
//   out_onehot   out  N_OUT  registered one-hot strobe (0 or exactly one bit)
//   out_active   out  1      high while a pulse is driven (|out_onehot)
//   err          out  1      registered one-cycle pulse: launched idx >= N_OUT
//   dbg_state_o  out  2      current FSM state (0=IDLE, 1=PULSE, 2=GAP)
// ---------------------------------------------------------------------------
module onehot_pulse_decoder #(
    parameter int N_OUT     = 8,
    parameter int IDX_W     = 3,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    output logic [N_OUT-1:0] out_onehot,
    output logic             out_active,
    output logic             err,
    output logic [1:0]       dbg_state_o
);

    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ?
                             ((PULSE_LEN > 2) ? PULSE_LEN : 2) :
                             ((GAP_LEN > 2) ? GAP_LEN : 2);
    localparam int CW = $clog2(MAX_LEN);

    localparam logic [CW-1:0]    PULSE_RELOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0]    GAP_RELOAD   = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    // One extra bit so the range check also works when N_OUT == 2**IDX_W.
    localparam logic [IDX_W:0]   N_OUT_LIM    = (IDX_W + 1)'(N_OUT);
    localparam logic [N_OUT-1:0] LINE0        = N_OUT'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_OUT-1:0]   onehot_q, onehot_d;
    logic               err_q, err_d;

    logic               accept;
    logic               ret_idle;
    logic               launch_go;
    logic [IDX_W-1:0]   launch_idx;

`ifdef DEC_PENDING_EN
    logic               pend_full_q, pend_full_d;
    logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
    logic               accept_used;

    assign in_ready = (state_q == IDLE) | ~pend_full_q;
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept      = in_valid & in_ready;
    assign out_onehot  = onehot_q;
    assign out_active  = |onehot_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        onehot_d   = onehot_q;
        err_d      = 1'b0;
        ret_idle   = 1'b0;
        launch_go  = 1'b0;
        launch_idx = in_idx;
`ifdef DEC_PENDING_EN
        pend_full_d = pend_full_q;
        pend_idx_d  = pend_idx_q;
        accept_used = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    launch_go = 1'b1;
`ifdef DEC_PENDING_EN
                    accept_used = 1'b1;
`endif
                end
            end
            PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    onehot_d = '0;
                    if (GAP_LEN > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_RELOAD;
                    end else begin
                        ret_idle = 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    ret_idle = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                onehot_d = '0;
            end
        endcase

        if (ret_idle) begin
            state_d = IDLE;
            cnt_d   = '0;
`ifdef DEC_PENDING_EN
            // Parked request goes first; with an empty slot a request arriving
            // on this very cycle launches directly instead of being parked.
            if (pend_full_q) begin
                launch_go   = 1'b1;
                launch_idx  = pend_idx_q;
                pend_full_d = 1'b0;
            end else if (accept) begin
                launch_go   = 1'b1;
                accept_used = 1'b1;
            end
`endif
        end

`ifdef DEC_PENDING_EN
        if (accept && !accept_used) begin
            pend_full_d = 1'b1;
            pend_idx_d  = in_idx;
        end
`endif

        // Out-of-range indices produce only an error strobe and no pulse.
        if (launch_go) begin
            if ({1'b0, launch_idx} < N_OUT_LIM) begin
                onehot_d = LINE0 << launch_idx;
                state_d  = PULSE;
                cnt_d    = PULSE_RELOAD;
            end else begin
                onehot_d = '0;
                err_d    = 1'b1;
                state_d  = IDLE;
                cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            onehot_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            err_q    <= err_d;
        end
    end

`ifdef DEC_PENDING_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_full_q <= 1'b0;
            pend_idx_q  <= '0;
        end else begin
            pend_full_q <= pend_full_d;
            pend_idx_q  <= pend_idx_d;
        end
    end
`endif

endmodule
